pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 13 +
 rtl/pc_target_sel.sv | 31 +++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU package: fetch FSM encoding and the default reset PC.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        HOLD_PEND
    } fetch_state_t;

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC target formation and redirect priority select.
module pc_target_sel (
    input  logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic [31:0] branch_off,
    input  logic        jump,
    input  logic [27:0] jump_addr,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] target,
    output logic        take
);

    // jr targets are word-aligned, so the low bits are ignored
    logic unused_jr_lsb;
    assign unused_jr_lsb = ^jr_addr[1:0];

    assign take = jr | jump | branch;

    always_comb begin
        target = pc_plus4;
        if (jr) begin
            target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            target = {pc_plus4[31:28], jump_addr};
        end else if (branch) begin
            target = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with stall handling and a pending-redirect buffer.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_off_i,
    input  logic        jump_i,
    input  logic [27:0] jump_addr_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        redirect_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pend_q;
    logic [31:0]  pend_d;
    logic         redir_q;
    logic         redir_d;
    logic [31:0]  target;
    logic         take;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
    assign valid_o    = (state_q != BOOT);
    assign redirect_o = redir_q;

    pc_target_sel u_sel (
        .pc_plus4   (pc_plus4_o),
        .branch     (branch_i),
        .branch_off (branch_off_i),
        .jump       (jump_i),
        .jump_addr  (jump_addr_i),
        .jr         (jr_i),
        .jr_addr    (jr_addr_i),
        .target     (target),
        .take       (take)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        redir_d = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (stall_i) begin
                    if (take) begin
                        pend_d  = target;
                        state_d = HOLD_PEND;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    pc_d    = target;
                    redir_d = take;
                    state_d = RUN;
                end
            end
            HOLD_PEND: begin
                if (stall_i) begin
                    // newest redirect replaces the buffered one
                    if (take) begin
                        pend_d = target;
                    end
                end else begin
                    pc_d    = take ? target : pend_q;
                    redir_d = 1'b1;
                    pend_d  = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_off = '0;
    logic        jump = 1'b0;
    logic [27:0] jump_addr = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        redirect;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // model: booting flag, PC, optional buffered target, redirect flag
    bit          m_boot = 1'b1;
    logic [31:0] m_pc = RST_PC;
    bit          m_has_pend = 1'b0;
    logic [31:0] m_pend = '0;
    bit          m_redir = 1'b0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .stall_i      (stall),
        .branch_i     (branch),
        .branch_off_i (branch_off),
        .jump_i       (jump),
        .jump_addr_i  (jump_addr),
        .jr_i         (jr),
        .jr_addr_i    (jr_addr),
        .pc_o         (pc),
        .pc_plus4_o   (pc_plus4),
        .valid_o      (valid),
        .redirect_o   (redirect)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur + 32'd4;
        if (jr)          return jr_addr & 32'hFFFF_FFFC;
        else if (jump)   return {nxt[31:28], jump_addr};
        else if (branch) return nxt + branch_off;
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot     = 1'b1;
            m_pc       = RST_PC;
            m_has_pend = 1'b0;
            m_redir    = 1'b0;
        end else if (m_boot) begin
            m_boot  = 1'b0;
            m_redir = 1'b0;
        end else begin
            if (stall) begin
                if (jr || jump || branch) begin
                    m_pend     = ref_target(m_pc);
                    m_has_pend = 1'b1;
                end
                m_redir = 1'b0;
            end else begin
                if (jr || jump || branch) begin
                    m_pc    = ref_target(m_pc);
                    m_redir = 1'b1;
                end else if (m_has_pend) begin
                    m_pc    = m_pend;
                    m_redir = 1'b1;
                end else begin
                    m_pc    = m_pc + 32'd4;
                    m_redir = 1'b0;
                end
                m_has_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pc", pc, m_pc);
            check("model_pc4", pc_plus4, m_pc + 32'd4);
            check("model_valid", {31'd0, valid}, {31'd0, !m_boot});
            check("model_redirect", {31'd0, redirect}, {31'd0, m_redir});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; branch = 0; jump = 0; jr = 0;
    endtask

    task automatic go_jr(input logic [31:0] a);
        jr = 1; jr_addr = a;
        step();
        clr();
    endtask

    initial begin
        clr();
        repeat (3) step();
        cmp_en = 1'b1;
        check("rst_pc", pc, RST_PC);
        check("rst_pc4", pc_plus4, RST_PC + 32'd4);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);

        rst_n = 1'b1;
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'd0, valid}, 32'd0);
        step();
        check("seq0_pc", pc, 32'h0);
        check("seq0_valid", {31'd0, valid}, 32'd1);
        step();
        check("seq1_pc", pc, 32'h4);
        step();
        check("seq2_pc", pc, 32'h8);
        step();
        check("seq3_pc", pc, 32'hC);

        go_jr(32'h0040_0010);
        check("jr_pc", pc, 32'h0040_0010);
        jump = 1; jump_addr = 28'h000_0100;
        step();
        clr();
        check("jump_pc", pc, 32'h0000_0100);
        check("jump_redir", {31'd0, redirect}, 32'd1);
        step();
        check("jump_redir_off", {31'd0, redirect}, 32'd0);
        check("after_jump_pc", pc, 32'h0000_0104);

        go_jr(32'h100);
        jr = 1; jump = 1; branch = 1;
        jr_addr = 32'h203; jump_addr = 28'h0000_800; branch_off = 32'h40;
        step();
        clr();
        check("prio_pc", pc, 32'h200);

        go_jr(32'h20);
        stall = 1; branch = 1; branch_off = 32'h40;
        step();
        check("stall1_pc", pc, 32'h20);
        branch = 0; jump = 1; jump_addr = 28'h80;
        step();
        check("stall2_pc", pc, 32'h20);
        jump = 0;
        step();
        check("stall3_pc", pc, 32'h20);
        stall = 0;
        step();
        check("release_pc", pc, 32'h80);
        check("release_redir", {31'd0, redirect}, 32'd1);

        go_jr(32'hFFFF_FFFC);
        check("top_pc", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_redir", {31'd0, redirect}, 32'd0);

        stall = 1; branch = 1; branch_off = 32'h1000;
        step();
        clr();
        stall = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        stall = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_boot_pc", pc, RST_PC);
        step();
        check("post_rst_seq_pc", pc, RST_PC + 32'd4);

        for (int i = 0; i < 3000; i++) begin
            stall      = ($urandom_range(0, 99) < 35);
            branch     = ($urandom_range(0, 99) < 15);
            jump       = ($urandom_range(0, 99) < 10);
            jr         = ($urandom_range(0, 99) < 10);
            branch_off = {{16{1'b0}}, 16'($urandom)} << 2;
            if ($urandom_range(0, 1) == 1) branch_off = -branch_off;
            jump_addr  = 28'($urandom) & 28'hFFF_FFFC;
            jr_addr    = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        clr();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
